operator_sweep: RTL and testbench
=================================

OPERATOR_SWEEP -- requirements
Module: operator_sweep

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; legal range 2..64.
REQ-002 Parameter CNT_W, default 16: width of the vector counter and of the result counters.
REQ-003 Port clk, input, 1: the single clock; every register is updated on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low; while it is 0 every register is held at its reset value.
REQ-005 Port start, input, 1: launches a sweep; sampled only in the IDLE state.
REQ-006 Port op, input, 3: predicate select, captured when start is accepted.
REQ-007 Port a_init and b_init, input, WIDTH each: first operand values, captured when start is accepted.
REQ-008 Port a_step and b_step, input, WIDTH each: per-vector increments, captured when start is accepted.
REQ-009 Port count, input, CNT_W: number of vectors to evaluate, captured when start is accepted.
REQ-010 Port busy, output, 1: high while the block is in LOAD or EVAL.
REQ-011 Port done, output, 1: one-cycle pulse marking the end of a sweep.
REQ-012 Port out1, output, 1: predicate result of the most recently evaluated vector.
REQ-013 Port hits, output, CNT_W: number of evaluated vectors for which the predicate was true.
REQ-014 Port first_idx, output, CNT_W, plus first_valid, output, 1: index of the first true vector, and a flag saying whether one exists.
REQ-015 Port fsm_state, output, 2: current state encoding, provided for observability.

Function
REQ-016 State encoding: IDLE=0, LOAD=1, EVAL=2, DONE=3.
REQ-017 IDLE with start=1 goes to LOAD and captures op, a_init, b_init, a_step, b_step and count.
  - start=0 stays in IDLE.
REQ-018 LOAD (one cycle):
  - sets a_cur=a_init, b_cur=b_init, idx=0;
  - clears hits, first_idx, first_valid and out1;
  - goes to DONE if the captured count is 0, otherwise goes to EVAL.
REQ-019 EVAL evaluates one vector per cycle with no stalls.
REQ-020 Predicate by op:
  - 0: a==b
  - 1: a!=b
  - 2: a<b, unsigned
  - 3: a>b, unsigned
  - 4: a<b, signed two's complement
  - 5: a>b, signed two's complement
  - 6: (a&b)!=0
  - 7: (a!=0)&&(b!=0)
REQ-021 Each EVAL cycle updates:
  - out1 <= predicate;
  - on a true predicate, hits <= hits+1;
  - on a true predicate with first_valid=0, first_idx <= idx and first_valid <= 1.
REQ-022 Each EVAL cycle also advances a_cur += a_step and b_cur += b_step, truncated modulo 2^WIDTH (wrap-around, no saturation), and sets idx <= idx+1.
REQ-023 The EVAL cycle with idx==count-1 is the last; the next state is DONE.
REQ-024 DONE lasts one cycle with done=1, then goes to IDLE; done is 0 in all other states.
REQ-025 Total latency: start accepted in cycle T gives done=1 in cycle T+count+2.
REQ-026 start is ignored in LOAD, EVAL and DONE; no queuing.
  - Input changes after capture do not affect a running sweep.
REQ-027 out1, hits, first_idx and first_valid hold their values after DONE until the next LOAD.
REQ-028 hits never exceeds count, so no overflow handling is required.
REQ-029 Inputs with count = 2^CNT_W-1 complete normally; idx does not wrap within a sweep.

Reset
REQ-030 Asserting reset (reset=0) at any time forces:
  - fsm_state=IDLE, busy=0, done=0, out1=0, hits=0, first_idx=0, first_valid=0;
  - all internal operand and counter registers to 0.
REQ-031 Reset taken in the middle of a sweep abandons it.
  - No done pulse is produced.
  - After reset is released, the block waits in IDLE for a new start.
REQ-032 On the first rising edge after reset goes high, the block is in IDLE and may accept start.

Verification
REQ-033 Equality sweep: op=0, a_init=0, b_init=1, a_step=1, b_step=0, count=4, start pulse.
  - Required: out1 sequence 0,1,0,0; hits=1; first_idx=1; first_valid=1; done exactly 6 cycles after start.
REQ-034 Signed vs unsigned: WIDTH=8, a_init=8'hFF, b_init=8'h01, count=1.
  - op=2: out1=0, hits=0.
  - op=4: out1=1, hits=1.
REQ-035 Wrap-around: WIDTH=8, op=0, a_init=8'hFE, a_step=1, b_init=8'h00, b_step=0, count=3.
  - Required: a_cur takes FE, FF, 00; hits=1; first_idx=2.
REQ-036 Zero count: count=0, start.
  - Required: done pulses 2 cycles after start; hits=0; first_valid=0; busy high for LOAD only.
REQ-037 Start while busy: a second start during EVAL of a count=5 sweep is ignored.
  - Required: exactly one done pulse; results match a single sweep.
REQ-038 Reset mid-sweep: reset=0 in EVAL with idx=2.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - Required: no done pulse; a new sweep afterwards produces correct results.

Source files
------------

// File: rtl/operator_sweep.sv
// operator_sweep: steps two operands through a programmed arithmetic sweep,
// evaluates a selectable comparison predicate on each vector and tallies
// the hit count and the index of the first hit.
module operator_sweep #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_init,
  input  logic [WIDTH-1:0] b_init,
  input  logic [WIDTH-1:0] a_step,
  input  logic [WIDTH-1:0] b_step,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             out1,
  output logic [CNT_W-1:0] hits,
  output logic [CNT_W-1:0] first_idx,
  output logic             first_valid,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_init_q, a_init_d;
  logic [WIDTH-1:0] b_init_q, b_init_d;
  logic [WIDTH-1:0] a_step_q, a_step_d;
  logic [WIDTH-1:0] b_step_q, b_step_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] a_cur_q, a_cur_d;
  logic [WIDTH-1:0] b_cur_q, b_cur_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic             first_valid_q, first_valid_d;
  logic             out1_q, out1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pred;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; the last vector is the one whose index is count-1
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: state_d = (count_q == '0) ? S_DONE : S_EVAL;
      S_EVAL: if (idx_q == count_q - CNT_W'(1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Predicate on the current operand pair
  always_comb begin
    pred = 1'b0;
    case (op_q)
      3'd0: pred = (a_cur_q == b_cur_q);
      3'd1: pred = (a_cur_q != b_cur_q);
      3'd2: pred = (a_cur_q < b_cur_q);
      3'd3: pred = (a_cur_q > b_cur_q);
      3'd4: pred = ($signed(a_cur_q) < $signed(b_cur_q));
      3'd5: pred = ($signed(a_cur_q) > $signed(b_cur_q));
      3'd6: pred = |(a_cur_q & b_cur_q);
      3'd7: pred = (|a_cur_q) && (|b_cur_q);
      default: pred = 1'b0;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    op_d          = op_q;
    a_init_d      = a_init_q;
    b_init_d      = b_init_q;
    a_step_d      = a_step_q;
    b_step_d      = b_step_q;
    count_d       = count_q;
    a_cur_d       = a_cur_q;
    b_cur_d       = b_cur_q;
    idx_d         = idx_q;
    hits_d        = hits_q;
    first_idx_d   = first_idx_q;
    first_valid_d = first_valid_q;
    out1_d        = out1_q;
    busy_d        = (state_d == S_LOAD) || (state_d == S_EVAL);
    done_d        = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          a_init_d = a_init;
          b_init_d = b_init;
          a_step_d = a_step;
          b_step_d = b_step;
          count_d  = count;
        end
      end
      S_LOAD: begin
        a_cur_d       = a_init_q;
        b_cur_d       = b_init_q;
        idx_d         = '0;
        hits_d        = '0;
        first_idx_d   = '0;
        first_valid_d = 1'b0;
        out1_d        = 1'b0;
      end
      S_EVAL: begin
        out1_d = pred;
        if (pred) begin
          hits_d = hits_q + CNT_W'(1);
          if (!first_valid_q) begin
            first_idx_d   = idx_q;
            first_valid_d = 1'b1;
          end
        end
        a_cur_d = a_cur_q + a_step_q;
        b_cur_d = b_cur_q + b_step_q;
        idx_d   = idx_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q          <= '0;
      a_init_q      <= '0;
      b_init_q      <= '0;
      a_step_q      <= '0;
      b_step_q      <= '0;
      count_q       <= '0;
      a_cur_q       <= '0;
      b_cur_q       <= '0;
      idx_q         <= '0;
      hits_q        <= '0;
      first_idx_q   <= '0;
      first_valid_q <= 1'b0;
      out1_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      op_q          <= op_d;
      a_init_q      <= a_init_d;
      b_init_q      <= b_init_d;
      a_step_q      <= a_step_d;
      b_step_q      <= b_step_d;
      count_q       <= count_d;
      a_cur_q       <= a_cur_d;
      b_cur_q       <= b_cur_d;
      idx_q         <= idx_d;
      hits_q        <= hits_d;
      first_idx_q   <= first_idx_d;
      first_valid_q <= first_valid_d;
      out1_q        <= out1_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign out1        = out1_q;
  assign hits        = hits_q;
  assign first_idx   = first_idx_q;
  assign first_valid = first_valid_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_operator_sweep.sv
// Directed testbench for operator_sweep (WIDTH=8, CNT_W=8).
module tb_operator_sweep;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] a_init, b_init, a_step, b_step;
  logic [7:0] count;
  logic       busy, done, out1, first_valid;
  logic [7:0] hits, first_idx;
  logic [1:0] fsm_state;

  int passed = 0;
  int total  = 0;

  operator_sweep #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a_init(a_init), .b_init(b_init), .a_step(a_step), .b_step(b_step),
    .count(count), .busy(busy), .done(done), .out1(out1), .hits(hits),
    .first_idx(first_idx), .first_valid(first_valid), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Advance one rising edge and settle
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a sweep and pulse start across one rising edge (edge 1)
  task automatic launch(input logic [2:0] o, input logic [7:0] ai, input logic [7:0] bi,
                        input logic [7:0] as, input logic [7:0] bs, input logic [7:0] cnt);
    @(negedge clk);
    op = o; a_init = ai; b_init = bi; a_step = as; b_step = bs; count = cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (fsm_state !== 2'd0) $display("FAIL rst_state got %0d want 0", fsm_state); else passed++;
    total++; if ({busy, done, out1, first_valid} !== 4'b0) $display("FAIL rst_flags got %b want 0000", {busy, done, out1, first_valid}); else passed++;
    total++; if ({hits, first_idx} !== 16'h0) $display("FAIL rst_counts got %h want 0000", {hits, first_idx}); else passed++;
    @(negedge clk); reset = 1'b1;
    step(); step();
    total++; if (fsm_state !== 2'd0 || busy !== 1'b0) $display("FAIL rst_idle got state=%0d busy=%b want 0/0", fsm_state, busy); else passed++;
  endtask

  task automatic test_equality();
    logic [3:0] exp_out;
    exp_out = 4'b0010;
    launch(3'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd4);
    total++; if (fsm_state !== 2'd1 || busy !== 1'b1) $display("FAIL eq_load got state=%0d busy=%b want 1/1", fsm_state, busy); else passed++;
    step();
    total++; if (fsm_state !== 2'd2 || busy !== 1'b1) $display("FAIL eq_eval got state=%0d busy=%b want 2/1", fsm_state, busy); else passed++;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (out1 !== exp_out[i]) $display("FAIL eq_out1_%0d got %b want %b", i, out1, exp_out[i]); else passed++;
      total++; if (done !== (i == 3)) $display("FAIL eq_done_edge%0d got %b want %b", i + 3, done, (i == 3)); else passed++;
    end
    total++; if (hits !== 8'd1) $display("FAIL eq_hits got %0d want 1", hits); else passed++;
    total++; if (first_idx !== 8'd1 || first_valid !== 1'b1) $display("FAIL eq_first got %0d/%b want 1/1", first_idx, first_valid); else passed++;
    step();
    total++; if (done !== 1'b0 || fsm_state !== 2'd0 || busy !== 1'b0) $display("FAIL eq_after got done=%b state=%0d busy=%b want 0/0/0", done, fsm_state, busy); else passed++;
    total++; if (hits !== 8'd1 || first_idx !== 8'd1 || first_valid !== 1'b1) $display("FAIL eq_hold got %0d/%0d/%b want 1/1/1", hits, first_idx, first_valid); else passed++;
  endtask

  task automatic test_predicates();
    logic [2:0] ops [10];
    logic [7:0] av  [10];
    logic [7:0] bv  [10];
    logic       ev  [10];
    ops[0] = 3'd2; av[0] = 8'hFF; bv[0] = 8'h01; ev[0] = 1'b0;
    ops[1] = 3'd4; av[1] = 8'hFF; bv[1] = 8'h01; ev[1] = 1'b1;
    ops[2] = 3'd3; av[2] = 8'hFF; bv[2] = 8'h01; ev[2] = 1'b1;
    ops[3] = 3'd5; av[3] = 8'hFF; bv[3] = 8'h01; ev[3] = 1'b0;
    ops[4] = 3'd6; av[4] = 8'h0C; bv[4] = 8'h03; ev[4] = 1'b0;
    ops[5] = 3'd6; av[5] = 8'h0C; bv[5] = 8'h04; ev[5] = 1'b1;
    ops[6] = 3'd7; av[6] = 8'h00; bv[6] = 8'h05; ev[6] = 1'b0;
    ops[7] = 3'd7; av[7] = 8'h80; bv[7] = 8'h01; ev[7] = 1'b1;
    ops[8] = 3'd1; av[8] = 8'h05; bv[8] = 8'h05; ev[8] = 1'b0;
    ops[9] = 3'd0; av[9] = 8'h07; bv[9] = 8'h07; ev[9] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      launch(ops[i], av[i], bv[i], 8'd0, 8'd0, 8'd1);
      step(); step();
      total++; if (done !== 1'b1 || out1 !== ev[i]) $display("FAIL pred_%0d op%0d got done=%b out1=%b want 1/%b", i, ops[i], done, out1, ev[i]); else passed++;
      total++; if (hits !== {7'd0, ev[i]}) $display("FAIL pred_hits_%0d got %0d want %0d", i, hits, ev[i]); else passed++;
      step();
    end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_out;
    exp_out = 3'b100;
    launch(3'd0, 8'hFE, 8'h00, 8'h01, 8'h00, 8'd3);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out1 !== exp_out[i]) $display("FAIL wrap_out1_%0d got %b want %b", i, out1, exp_out[i]); else passed++;
    end
    total++; if (done !== 1'b1) $display("FAIL wrap_done got %b want 1", done); else passed++;
    total++; if (hits !== 8'd1 || first_idx !== 8'd2 || first_valid !== 1'b1) $display("FAIL wrap_result got %0d/%0d/%b want 1/2/1", hits, first_idx, first_valid); else passed++;
    step();
  endtask

  task automatic test_zero_count();
    launch(3'd0, 8'd3, 8'd3, 8'd0, 8'd0, 8'd0);
    total++; if (busy !== 1'b1 || done !== 1'b0 || fsm_state !== 2'd1) $display("FAIL zero_load got busy=%b done=%b state=%0d want 1/0/1", busy, done, fsm_state); else passed++;
    step();
    total++; if (busy !== 1'b0 || done !== 1'b1 || fsm_state !== 2'd3) $display("FAIL zero_done got busy=%b done=%b state=%0d want 0/1/3", busy, done, fsm_state); else passed++;
    total++; if (hits !== 8'd0 || first_valid !== 1'b0 || out1 !== 1'b0) $display("FAIL zero_result got %0d/%b/%b want 0/0/0", hits, first_valid, out1); else passed++;
    step();
    total++; if (done !== 1'b0 || fsm_state !== 2'd0) $display("FAIL zero_after got done=%b state=%0d want 0/0", done, fsm_state); else passed++;
  endtask

  task automatic test_back_to_back();
    int done_n;
    int done_at;
    done_n = 0; done_at = 0;
    launch(3'd2, 8'd0, 8'd3, 8'd1, 8'd0, 8'd5);
    for (int e = 2; e <= 20; e++) begin
      if (e == 3) begin
        @(negedge clk);
        start = 1'b1; op = 3'd0; count = 8'd1; a_init = 8'd9; b_init = 8'd9; a_step = 8'd7;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = e;
      end
    end
    total++; if (done_n !== 1) $display("FAIL b2b_done_count got %0d want 1", done_n); else passed++;
    total++; if (done_at !== 7) $display("FAIL b2b_done_edge got %0d want 7", done_at); else passed++;
    total++; if (hits !== 8'd3 || first_idx !== 8'd0 || first_valid !== 1'b1) $display("FAIL b2b_result got %0d/%0d/%b want 3/0/1", hits, first_idx, first_valid); else passed++;
    total++; if (fsm_state !== 2'd0 || busy !== 1'b0) $display("FAIL b2b_idle got state=%0d busy=%b want 0/0", fsm_state, busy); else passed++;
  endtask

  task automatic test_reset_mid_sweep();
    int done_n;
    int done_at;
    done_n = 0; done_at = 0;
    launch(3'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd5);
    step(); step(); step();
    total++; if (fsm_state !== 2'd2 || out1 !== 1'b1 || hits !== 8'd1) $display("FAIL mid_pre got state=%0d out1=%b hits=%0d want 2/1/1", fsm_state, out1, hits); else passed++;
    reset = 1'b0;
    #1;
    total++; if (fsm_state !== 2'd0 || {busy, done, out1, first_valid} !== 4'b0 || {hits, first_idx} !== 16'h0) $display("FAIL mid_async got state=%0d flags=%b counts=%h want 0/0000/0000", fsm_state, {busy, done, out1, first_valid}, {hits, first_idx}); else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) done_n++;
    end
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done || fsm_state != 2'd0) done_n++;
    end
    total++; if (done_n !== 0) $display("FAIL mid_no_done got %0d events want 0", done_n); else passed++;
    launch(3'd3, 8'd5, 8'd2, 8'd0, 8'd1, 8'd4);
    for (int e = 2; e <= 12 && done_at == 0; e++) begin
      step();
      if (done) done_at = e;
    end
    total++; if (done_at !== 6) $display("FAIL mid_new_done_edge got %0d want 6", done_at); else passed++;
    total++; if (hits !== 8'd3 || first_idx !== 8'd0 || first_valid !== 1'b1 || out1 !== 1'b0) $display("FAIL mid_new_result got %0d/%0d/%b/%b want 3/0/1/0", hits, first_idx, first_valid, out1); else passed++;
    step();
  endtask

  task automatic test_max_count();
    int done_at;
    done_at = 0;
    launch(3'd0, 8'd0, 8'h80, 8'd1, 8'd0, 8'd255);
    for (int e = 2; e <= 300 && done_at == 0; e++) begin
      step();
      if (done) done_at = e;
    end
    total++; if (done_at !== 257) $display("FAIL max_done_edge got %0d want 257", done_at); else passed++;
    total++; if (hits !== 8'd1 || first_idx !== 8'd128 || first_valid !== 1'b1) $display("FAIL max_eq_result got %0d/%0d/%b want 1/128/1", hits, first_idx, first_valid); else passed++;
    step();
    done_at = 0;
    launch(3'd7, 8'd1, 8'd1, 8'd0, 8'd0, 8'd255);
    for (int e = 2; e <= 300 && done_at == 0; e++) begin
      step();
      if (done) done_at = e;
    end
    total++; if (done_at !== 257) $display("FAIL max_all_done_edge got %0d want 257", done_at); else passed++;
    total++; if (hits !== 8'd255 || first_idx !== 8'd0 || first_valid !== 1'b1) $display("FAIL max_all_result got %0d/%0d/%b want 255/0/1", hits, first_idx, first_valid); else passed++;
    step();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0;
    a_init = 8'd0; b_init = 8'd0; a_step = 8'd0; b_step = 8'd0; count = 8'd0;
    #12;
    test_reset();
    test_equality();
    test_predicates();
    test_wrap();
    test_zero_count();
    test_back_to_back();
    test_reset_mid_sweep();
    test_max_count();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
